// File: rtl/cdr_frame_sync.sv
// Frame aligner/deserializer behind the CDR: hunts for a sync word, verifies it, then
// streams payload bytes through a small FIFO. A miss flywheel holds lock across corrupt syncs.
module cdr_frame_sync #(
  parameter int unsigned           SYNC_BITS   = 16,
  parameter logic [SYNC_BITS-1:0]  SYNC_WORD   = 16'hF628,
  parameter int unsigned           FRAME_BYTES = 4,
  parameter int unsigned           VERIFY_CNT  = 2,
  parameter int unsigned           MISS_MAX    = 3,
  parameter int unsigned           FIFO_DEPTH  = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       sample_en_i,
  input  logic       d_bb_i,
  output logic [7:0] m_data_o,
  output logic       m_last_o,
  output logic       m_valid_o,
  input  logic       m_ready_i,
  output logic       locked_o,
  output logic [1:0] state_o,
  output logic       sync_miss_o,
  output logic       ovf_o
);

  localparam int unsigned P        = 8 * FRAME_BYTES;
  localparam int unsigned FrameLen = P + SYNC_BITS;
  localparam int unsigned BcW      = $clog2(FrameLen);
  localparam int unsigned GoodW    = $clog2(VERIFY_CNT + 1);
  localparam int unsigned MissW    = $clog2(MISS_MAX + 1);
  localparam int unsigned AddrW    = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StHunt   = 2'd0,
    StVerify = 2'd1,
    StLock   = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [SYNC_BITS-1:0] sr_q, sr_d, sr_shift;
  logic [BcW-1:0]       bc_q, bc_d, bc_next;
  logic [GoodW-1:0]     good_q, good_d, good_inc;
  logic [MissW-1:0]     miss_q, miss_d, miss_inc;
  logic [7:0]           asm_q, asm_d, asm_shift;
  logic                 sync_miss_q, sync_miss_d;
  logic                 ovf_q;
  logic                 match, at_check, in_payload, last_byte;
  logic                 push, push_last;

  assign sr_shift   = {sr_q[SYNC_BITS-2:0], d_bb_i};
  assign match      = (sr_shift == SYNC_WORD);
  assign at_check   = (bc_q == BcW'(FrameLen - 1));
  assign in_payload = (bc_q < BcW'(P));
  assign last_byte  = (bc_q[BcW-1:3] == (BcW-3)'(FRAME_BYTES - 1));
  assign bc_next    = at_check ? '0 : bc_q + BcW'(1);
  assign good_inc   = good_q + GoodW'(1);
  assign miss_inc   = miss_q + MissW'(1);
  assign asm_shift  = {asm_q[6:0], d_bb_i};

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (sample_en_i) begin
      unique case (state_q)
        StHunt: begin
          if (match) state_d = StVerify;
        end
        StVerify: begin
          if (at_check) begin
            if (!match) begin
              state_d = StHunt;
            end else if (good_inc == GoodW'(VERIFY_CNT)) begin
              state_d = StLock;
            end
          end
        end
        StLock: begin
          if (at_check && !match && (miss_inc == MissW'(MISS_MAX))) state_d = StHunt;
        end
        default: state_d = StHunt;
      endcase
    end
  end

  // Outputs decoded from state
  always_comb begin
    locked_o = (state_q == StLock);
    state_o  = state_q;
  end

  // Frame counter, verify/miss counters and byte assembler
  always_comb begin
    sr_d        = sr_q;
    bc_d        = bc_q;
    good_d      = good_q;
    miss_d      = miss_q;
    asm_d       = asm_q;
    push        = 1'b0;
    push_last   = 1'b0;
    sync_miss_d = 1'b0;
    if (sample_en_i) begin
      sr_d = sr_shift;
      unique case (state_q)
        StHunt: begin
          bc_d   = '0;
          good_d = '0;
          miss_d = '0;
          asm_d  = '0;
        end
        StVerify: begin
          bc_d = bc_next;
          if (at_check) begin
            if (match) begin
              good_d = good_inc;
              miss_d = '0;
            end else begin
              sync_miss_d = 1'b1;
            end
          end
        end
        StLock: begin
          bc_d = bc_next;
          if (in_payload) begin
            asm_d = asm_shift;
            if (bc_q[2:0] == 3'd7) begin
              push      = 1'b1;
              push_last = last_byte;
            end
          end
          if (at_check) begin
            if (match) begin
              miss_d = '0;
            end else begin
              sync_miss_d = 1'b1;
              miss_d      = miss_inc;
            end
          end
          // Dropping out of lock throws away any partially assembled byte
          if (state_d != StLock) asm_d = '0;
        end
        default: begin
          bc_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sr_q        <= '0;
      bc_q        <= '0;
      good_q      <= '0;
      miss_q      <= '0;
      asm_q       <= '0;
      sync_miss_q <= 1'b0;
    end else begin
      sr_q        <= sr_d;
      bc_q        <= bc_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      asm_q       <= asm_d;
      sync_miss_q <= sync_miss_d;
    end
  end

  assign sync_miss_o = sync_miss_q;

  // Output FIFO: pointers carry one extra wrap bit to tell full from empty
  logic [AddrW:0]   wr_ptr_q, rd_ptr_q, fifo_cnt;
  logic [8:0]       mem_q [FIFO_DEPTH];
  logic             fifo_full, pop, push_ok;

  assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
  assign fifo_full = (fifo_cnt == (AddrW+1)'(FIFO_DEPTH));
  assign m_valid_o = (wr_ptr_q != rd_ptr_q);
  assign pop       = m_valid_o & m_ready_i;
  assign push_ok   = push & (~fifo_full | pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AddrW+1)'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + (AddrW+1)'(1);
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AddrW-1:0]] <= {push_last, asm_shift};
  end

  assign {m_last_o, m_data_o} = m_valid_o ? mem_q[rd_ptr_q[AddrW-1:0]] : 9'h000;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_cdr_frame_sync.sv
// Directed bench for cdr_frame_sync: frames are sent as payload then sync word,
// one bit per strobe, strobe every second clock.
module tb_cdr_frame_sync;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample_en = 1'b0;
  logic       d_bb = 1'b0;
  logic       m_ready = 1'b1;
  logic [7:0] m_data;
  logic       m_last, m_valid, locked, sync_miss, ovf;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] got_q[$];
  int         miss_seen = 0;

  always #5 clk = ~clk;

  cdr_frame_sync dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .sample_en_i (sample_en),
    .d_bb_i      (d_bb),
    .m_data_o    (m_data),
    .m_last_o    (m_last),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .locked_o    (locked),
    .state_o     (state),
    .sync_miss_o (sync_miss),
    .ovf_o       (ovf)
  );

  // Capture accepted bytes and sync_miss pulses just after each falling edge
  always begin
    @(negedge clk);
    #1;
    if (rst_n) begin
      if (m_valid && m_ready) got_q.push_back({m_last, m_data});
      if (sync_miss) miss_seen++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    sample_en = 1'b1;
    d_bb      = b;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [31:0] pay, input logic [15:0] sync);
    send_bits(pay, 32);
    send_bits({16'h0, sync}, 16);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    sample_en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    m_ready = 1'b1;
  endtask

  task automatic lock_up();
    for (int f = 0; f < 3; f++) send_frame(32'h0, 16'hF628);
    n_tests++;
    if (state !== 2'd2) begin
      n_fail++;
      $display("FAIL lock_up_state: got %0d want 2", state);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst_n     = 1'b0;
      sample_en = 1'($urandom_range(0, 1));
      d_bb      = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    n_tests++;
    if (state !== 2'd0)    begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_tests++;
    if (locked !== 1'b0)   begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_tests++;
    if (m_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b want 0", m_valid); end
    n_tests++;
    if (ovf !== 1'b0)      begin n_fail++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    n_tests++;
    if (sync_miss !== 1'b0) begin n_fail++; $display("FAIL reset_miss: got %b want 0", sync_miss); end
    n_tests++;
    if ({m_last, m_data} !== 9'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h want 000", {m_last, m_data});
    end
    sample_en = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic test_clean_lock();
    int base, mbase;
    base  = got_q.size();
    mbase = miss_seen;
    send_frame(32'h01020304, 16'hF628);
    n_tests++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL lock_f1_verify: got %0d want 1", state); end
    send_frame(32'h01020304, 16'hF628);
    n_tests++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL lock_f2_verify: got %0d want 1", state); end
    send_bits(32'h01020304, 32);
    n_tests++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_f3_early: got %b want 0", locked); end
    send_bits(32'h0000F628, 16);
    n_tests++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_f3_locked: got %b want 1", locked); end
    send_frame(32'h01020304, 16'hF628);
    send_frame(32'h01020304, 16'hF628);
    idle(4);
    n_tests++;
    if (got_q.size() - base !== 8) begin
      n_fail++;
      $display("FAIL lock_count: got %0d want 8", got_q.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        logic [8:0] exp;
        exp = {((i % 4) == 3), 8'((i % 4) + 1)};
        n_tests++;
        if (got_q[base+i] !== exp) begin
          n_fail++;
          $display("FAIL lock_byte%0d: got %h want %h", i, got_q[base+i], exp);
        end
      end
    end
    n_tests++;
    if (miss_seen - mbase !== 0) begin
      n_fail++;
      $display("FAIL lock_no_miss: got %0d want 0", miss_seen - mbase);
    end
  endtask

  task automatic test_flywheel();
    int base, mbase;
    base  = got_q.size();
    mbase = miss_seen;
    send_frame(32'hAABBCCDD, 16'hF629);
    idle(4);
    n_tests++;
    if (locked !== 1'b1) begin n_fail++; $display("FAIL fly_hold: got %b want 1", locked); end
    n_tests++;
    if (miss_seen - mbase !== 1) begin
      n_fail++;
      $display("FAIL fly_one_miss: got %0d want 1", miss_seen - mbase);
    end
    n_tests++;
    if (got_q.size() - base !== 4) begin
      n_fail++;
      $display("FAIL fly_bytes: got %0d want 4", got_q.size() - base);
    end else begin
      n_tests++;
      if (got_q[base] !== 9'h0AA || got_q[base+3] !== 9'h1DD) begin
        n_fail++;
        $display("FAIL fly_data: got %h..%h want 0aa..1dd", got_q[base], got_q[base+3]);
      end
    end
    send_frame(32'h11223344, 16'hF628);
    base  = got_q.size();
    mbase = miss_seen;
    send_frame(32'h55667788, 16'h0000);
    send_frame(32'h55667788, 16'h0000);
    n_tests++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL fly_miss2_state: got %0d want 2", state); end
    send_frame(32'h55667788, 16'h0000);
    n_tests++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL fly_miss3_hunt: got %0d want 0", state); end
    send_bits(32'h00000A5A, 12);
    idle(6);
    n_tests++;
    if (got_q.size() - base !== 12) begin
      n_fail++;
      $display("FAIL fly_after_hunt: got %0d want 12", got_q.size() - base);
    end
    n_tests++;
    if (miss_seen - mbase !== 3) begin
      n_fail++;
      $display("FAIL fly_three_miss: got %0d want 3", miss_seen - mbase);
    end
  endtask

  task automatic test_overflow();
    int base;
    do_reset();
    lock_up();
    m_ready = 1'b0;
    base    = got_q.size();
    send_bits(32'h00000010, 8);
    n_tests++;
    if ({m_valid, m_last, m_data} !== 10'h210) begin
      n_fail++;
      $display("FAIL ovf_first_push: got %h want 210", {m_valid, m_last, m_data});
    end
    send_bits(32'h00111213, 24);
    n_tests++;
    if (ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_early: got %b want 0", ovf); end
    send_bits(32'h0000F628, 16);
    send_bits(32'h00000014, 8);
    n_tests++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_fifth: got %b want 1", ovf); end
    send_bits(32'h00151617, 24);
    send_bits(32'h0000F628, 16);
    m_ready = 1'b1;
    idle(8);
    n_tests++;
    if (got_q.size() - base !== 4) begin
      n_fail++;
      $display("FAIL ovf_drain_count: got %0d want 4", got_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [8:0] exp;
        exp = {(i == 3), 8'(8'h10 + i)};
        n_tests++;
        if (got_q[base+i] !== exp) begin
          n_fail++;
          $display("FAIL ovf_drain%0d: got %h want %h", i, got_q[base+i], exp);
        end
      end
    end
    n_tests++;
    if (m_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", m_valid); end
    n_tests++;
    if (ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
  endtask

  task automatic test_false_sync();
    int base, mbase;
    do_reset();
    base  = got_q.size();
    mbase = miss_seen;
    send_bits(32'h00000000, 8);
    send_bits(32'h0000F628, 16);
    n_tests++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL false_verify: got %0d want 1", state); end
    send_bits(32'h12345678, 32);
    send_bits(32'h00000000, 16);
    n_tests++;
    if (state !== 2'd0) begin n_fail++; $display("FAIL false_hunt: got %0d want 0", state); end
    send_bits(32'h00000000, 8);
    idle(4);
    n_tests++;
    if (miss_seen - mbase !== 1) begin
      n_fail++;
      $display("FAIL false_miss: got %0d want 1", miss_seen - mbase);
    end
    n_tests++;
    if (got_q.size() - base !== 0) begin
      n_fail++;
      $display("FAIL false_bytes: got %0d want 0", got_q.size() - base);
    end
  endtask

  task automatic test_mid_reset();
    int base;
    do_reset();
    lock_up();
    m_ready = 1'b0;
    send_bits(32'h00002122, 16);
    send_bits(32'h00000003, 4);
    n_tests++;
    if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_prefill: got %b want 1", m_valid); end
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({state, locked, m_valid, m_last, m_data, ovf, sync_miss} !== 15'h0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h want 0000",
               {state, locked, m_valid, m_last, m_data, ovf, sync_miss});
    end
    rst_n   = 1'b1;
    m_ready = 1'b1;
    base    = got_q.size();
    send_frame(32'h0, 16'hF628);
    n_tests++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL mid_relock1: got %0d want 1", state); end
    send_frame(32'h0, 16'hF628);
    n_tests++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL mid_relock2: got %0d want 1", state); end
    send_frame(32'h0, 16'hF628);
    n_tests++;
    if (state !== 2'd2) begin n_fail++; $display("FAIL mid_relock3: got %0d want 2", state); end
    idle(4);
    n_tests++;
    if (got_q.size() - base !== 0) begin
      n_fail++;
      $display("FAIL mid_no_bytes: got %0d want 0", got_q.size() - base);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_flywheel();
    test_overflow();
    test_false_sync();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
